// File: rtl/counter_mod.sv
// Purpose: parametrised modulo counter with load, up/down, prescaler and wrap/saturate/one-shot end modes.
// Latency: q, wrap and done update one ck edge after the inputs that cause them; tc is combinational on q/up.
// Backpressure: none; en (through the prescaler) gates stepping, load and res take priority every cycle.
module counter_mod #(
    parameter int     WIDTH    = 4,
    parameter longint MODULUS  = 16,
    parameter int     PRESCALE = 1
) (
    input  logic             ck,
    input  logic             res,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap,
    output logic             done
);

    // Prescaler phase counter is at least one bit wide even when PRESCALE == 1.
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    // Top of range kept in WIDTH+1 bits so MODULUS == 2^WIDTH does not overflow.
    localparam logic [WIDTH:0]   Q_MAX_EXT = (WIDTH+1)'(MODULUS - 1);
    localparam logic [WIDTH-1:0] Q_MAX     = Q_MAX_EXT[WIDTH-1:0];
    localparam logic [PW-1:0]    PRE_MAX   = PW'(PRESCALE - 1);

    localparam logic [1:0] MODE_SAT     = 2'b01;
    localparam logic [1:0] MODE_ONESHOT = 2'b10;

    logic [PW-1:0]    pre;
    logic             tick;
    logic             at_max;
    logic             at_min;
    logic             at_end;
    logic [WIDTH-1:0] d_clamped;

    // End-of-range detection, terminal count and load clamping.
    always_comb begin
        at_max    = ({1'b0, q} == Q_MAX_EXT);
        at_min    = (q == '0);
        at_end    = up ? at_max : at_min;
        tc        = at_end;
        tick      = en && (pre == PRE_MAX);
        d_clamped = ({1'b0, d} > Q_MAX_EXT) ? Q_MAX : d;
    end

    // Counter, prescaler and status flags; priority res > load > tick > hold.
    always_ff @(posedge ck) begin
        if (res) begin
            q    <= '0;
            pre  <= '0;
            wrap <= 1'b0;
            done <= 1'b0;
        end else if (load) begin
            // Load restarts the prescaler so the next step needs a full PRESCALE window.
            q    <= d_clamped;
            pre  <= '0;
            wrap <= 1'b0;
            done <= 1'b0;
        end else begin
            wrap <= 1'b0;
            if (en) begin
                pre <= (pre == PRE_MAX) ? '0 : pre + PW'(1);
            end
            if (done) begin
                // One-shot finished: freeze q until load/res, or until mode leaves one-shot.
                if (mode != MODE_ONESHOT) begin
                    done <= 1'b0;
                end
            end else if (tick) begin
                if (!at_end) begin
                    q <= up ? q + WIDTH'(1) : q - WIDTH'(1);
                end else begin
                    case (mode)
                        MODE_SAT:     q <= q;
                        MODE_ONESHOT: done <= 1'b1;
                        // Wrap mode; the reserved encoding behaves the same way.
                        default: begin
                            q    <= up ? '0 : Q_MAX;
                            wrap <= 1'b1;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_counter_mod.sv
// Purpose: directed self-checking bench for counter_mod across default, modulus-10 and prescale-3 instances.
// Latency: inputs change 1 time unit after a rising edge; outputs are sampled at the same offset.
// Backpressure: not applicable; every step is a fixed number of clock edges.
module tb_counter_mod;

    logic       ck;
    logic       res;
    logic       en;
    logic       up;
    logic       load;
    logic [3:0] d;
    logic [1:0] mode;

    logic [3:0] q_a, q_b, q_c;
    logic       tc_a, tc_b, tc_c;
    logic       wrap_a, wrap_b, wrap_c;
    logic       done_a, done_b, done_c;

    int checks = 0;
    int errors = 0;

    counter_mod #(.WIDTH(4), .MODULUS(16), .PRESCALE(1)) u_def (
        .ck(ck), .res(res), .en(en), .up(up), .load(load), .d(d), .mode(mode),
        .q(q_a), .tc(tc_a), .wrap(wrap_a), .done(done_a)
    );

    counter_mod #(.WIDTH(4), .MODULUS(10), .PRESCALE(1)) u_m10 (
        .ck(ck), .res(res), .en(en), .up(up), .load(load), .d(d), .mode(mode),
        .q(q_b), .tc(tc_b), .wrap(wrap_b), .done(done_b)
    );

    counter_mod #(.WIDTH(4), .MODULUS(10), .PRESCALE(3)) u_ps3 (
        .ck(ck), .res(res), .en(en), .up(up), .load(load), .d(d), .mode(mode),
        .q(q_c), .tc(tc_c), .wrap(wrap_c), .done(done_c)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    // Advance one rising edge and settle just after it.
    task automatic clk1();
        @(posedge ck);
        #1;
    endtask

    // Reset wins over simultaneous load and enable.
    task automatic test_reset();
        res = 1'b1; load = 1'b1; en = 1'b1; up = 1'b1; mode = 2'b00; d = 4'd5;
        clk1();
        checks++; if (q_a !== 4'd0) begin errors++; $display("FAIL reset_q_def got %0d expected 0", q_a); end
        checks++; if (q_b !== 4'd0) begin errors++; $display("FAIL reset_q_m10 got %0d expected 0", q_b); end
        checks++; if (q_c !== 4'd0) begin errors++; $display("FAIL reset_q_ps3 got %0d expected 0", q_c); end
        checks++; if (wrap_a !== 1'b0) begin errors++; $display("FAIL reset_wrap got %b expected 0", wrap_a); end
        checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL reset_done got %b expected 0", done_a); end
        checks++; if (tc_a !== 1'b0) begin errors++; $display("FAIL reset_tc got %b expected 0", tc_a); end
        res = 1'b0; load = 1'b0;
    endtask

    // Default instance behaves as a plain 4-bit wrap-around counter.
    task automatic test_default_count();
        int   exp_q;
        logic exp_w;
        res = 1'b1; load = 1'b0; en = 1'b1; up = 1'b1; mode = 2'b00; d = 4'd0;
        clk1();
        res = 1'b0;
        exp_q = 0;
        checks++; if (q_a !== 4'd0) begin errors++; $display("FAIL cnt_start got %0d expected 0", q_a); end
        for (int i = 0; i < 19; i++) begin
            clk1();
            exp_w = (exp_q == 15);
            exp_q = (exp_q + 1) % 16;
            checks++; if (q_a !== 4'(exp_q)) begin errors++; $display("FAIL cnt_q step %0d got %0d expected %0d", i, q_a, exp_q); end
            checks++; if (wrap_a !== exp_w) begin errors++; $display("FAIL cnt_wrap step %0d got %b expected %b", i, wrap_a, exp_w); end
            checks++; if (tc_a !== (exp_q == 15)) begin errors++; $display("FAIL cnt_tc step %0d got %b expected %b", i, tc_a, exp_q == 15); end
        end
    endtask

    // Modulus 10 counting down through zero, then a clamped load.
    task automatic test_down_load();
        logic [3:0] eq [4];
        logic       ew [4];
        logic       et [4];
        eq = '{4'd1, 4'd0, 4'd9, 4'd8};
        ew = '{1'b0, 1'b0, 1'b1, 1'b0};
        et = '{1'b0, 1'b1, 1'b0, 1'b0};
        up = 1'b0; mode = 2'b00; en = 1'b1; load = 1'b1; d = 4'd2;
        clk1();
        load = 1'b0;
        checks++; if (q_b !== 4'd2) begin errors++; $display("FAIL down_load got %0d expected 2", q_b); end
        for (int i = 0; i < 4; i++) begin
            clk1();
            checks++; if (q_b !== eq[i]) begin errors++; $display("FAIL down_q step %0d got %0d expected %0d", i, q_b, eq[i]); end
            checks++; if (wrap_b !== ew[i]) begin errors++; $display("FAIL down_wrap step %0d got %b expected %b", i, wrap_b, ew[i]); end
            checks++; if (tc_b !== et[i]) begin errors++; $display("FAIL down_tc step %0d got %b expected %b", i, tc_b, et[i]); end
        end
        load = 1'b1; d = 4'd12;
        clk1();
        load = 1'b0;
        checks++; if (q_b !== 4'd9) begin errors++; $display("FAIL clamp_load got %0d expected 9", q_b); end
    endtask

    // Saturate mode holds at the top, then counts down after a direction change.
    task automatic test_saturate();
        logic [3:0] eq [6];
        eq = '{4'd8, 4'd9, 4'd9, 4'd9, 4'd9, 4'd9};
        up = 1'b1; mode = 2'b01; en = 1'b1; load = 1'b1; d = 4'd7;
        clk1();
        load = 1'b0;
        for (int i = 0; i < 6; i++) begin
            clk1();
            checks++; if (q_b !== eq[i]) begin errors++; $display("FAIL sat_q step %0d got %0d expected %0d", i, q_b, eq[i]); end
            checks++; if (wrap_b !== 1'b0) begin errors++; $display("FAIL sat_wrap step %0d got %b expected 0", i, wrap_b); end
        end
        checks++; if (tc_b !== 1'b1) begin errors++; $display("FAIL sat_tc got %b expected 1", tc_b); end
        up = 1'b0;
        clk1();
        checks++; if (q_b !== 4'd8) begin errors++; $display("FAIL sat_down1 got %0d expected 8", q_b); end
        clk1();
        checks++; if (q_b !== 4'd7) begin errors++; $display("FAIL sat_down2 got %0d expected 7", q_b); end
    endtask

    // One-shot stops and flags done; leaving the mode or a load restarts counting.
    task automatic test_oneshot();
        logic [3:0] eq [5];
        logic       ed [5];
        eq = '{4'd8, 4'd9, 4'd9, 4'd9, 4'd9};
        ed = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        up = 1'b1; mode = 2'b10; en = 1'b1; load = 1'b1; d = 4'd7;
        clk1();
        load = 1'b0;
        checks++; if (done_b !== 1'b0) begin errors++; $display("FAIL os_load_done got %b expected 0", done_b); end
        for (int i = 0; i < 5; i++) begin
            clk1();
            checks++; if (q_b !== eq[i]) begin errors++; $display("FAIL os_q step %0d got %0d expected %0d", i, q_b, eq[i]); end
            checks++; if (done_b !== ed[i]) begin errors++; $display("FAIL os_done step %0d got %b expected %b", i, done_b, ed[i]); end
        end
        mode = 2'b00;
        clk1();
        checks++; if (done_b !== 1'b0 || q_b !== 4'd9) begin errors++; $display("FAIL os_leave got q=%0d done=%b expected q=9 done=0", q_b, done_b); end
        clk1();
        checks++; if (q_b !== 4'd0 || wrap_b !== 1'b1) begin errors++; $display("FAIL os_resume got q=%0d wrap=%b expected q=0 wrap=1", q_b, wrap_b); end
        mode = 2'b10; load = 1'b1; d = 4'd9;
        clk1();
        load = 1'b0;
        clk1();
        checks++; if (done_b !== 1'b1) begin errors++; $display("FAIL os_done2 got %b expected 1", done_b); end
        load = 1'b1; d = 4'd0;
        clk1();
        load = 1'b0;
        checks++; if (done_b !== 1'b0 || q_b !== 4'd0) begin errors++; $display("FAIL os_reload got q=%0d done=%b expected q=0 done=0", q_b, done_b); end
        clk1();
        checks++; if (q_b !== 4'd1) begin errors++; $display("FAIL os_count got %0d expected 1", q_b); end
    endtask

    // Prescale 3: a step every third enabled cycle; load restarts the phase.
    task automatic test_prescale();
        logic       en_seq [7];
        logic [3:0] eq [7];
        en_seq = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        eq     = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd1, 4'd1, 4'd2};
        res = 1'b1; load = 1'b0; up = 1'b1; mode = 2'b00; en = 1'b0;
        clk1();
        res = 1'b0;
        for (int i = 0; i < 7; i++) begin
            en = en_seq[i];
            clk1();
            checks++; if (q_c !== eq[i]) begin errors++; $display("FAIL ps_q step %0d got %0d expected %0d", i, q_c, eq[i]); end
        end
        en = 1'b1;
        clk1();
        clk1();
        checks++; if (q_c !== 4'd2) begin errors++; $display("FAIL ps_pre2 got %0d expected 2", q_c); end
        load = 1'b1; d = 4'd4;
        clk1();
        load = 1'b0;
        checks++; if (q_c !== 4'd4) begin errors++; $display("FAIL ps_load got %0d expected 4", q_c); end
        clk1();
        checks++; if (q_c !== 4'd4) begin errors++; $display("FAIL ps_after_load1 got %0d expected 4", q_c); end
        clk1();
        checks++; if (q_c !== 4'd4) begin errors++; $display("FAIL ps_after_load2 got %0d expected 4", q_c); end
        clk1();
        checks++; if (q_c !== 4'd5) begin errors++; $display("FAIL ps_after_load3 got %0d expected 5", q_c); end
        en = 1'b0;
    endtask

    // Load beats a wrapping tick; reserved mode wraps like mode 00.
    task automatic test_back_to_back();
        up = 1'b1; mode = 2'b00; en = 1'b1; load = 1'b1; d = 4'd15;
        clk1();
        checks++; if (q_a !== 4'd15 || tc_a !== 1'b1) begin errors++; $display("FAIL b2b_top got q=%0d tc=%b expected q=15 tc=1", q_a, tc_a); end
        d = 4'd3;
        clk1();
        load = 1'b0;
        checks++; if (q_a !== 4'd3 || wrap_a !== 1'b0) begin errors++; $display("FAIL b2b_load_tick got q=%0d wrap=%b expected q=3 wrap=0", q_a, wrap_a); end
        load = 1'b1; d = 4'd15; mode = 2'b11;
        clk1();
        load = 1'b0;
        clk1();
        checks++; if (q_a !== 4'd0 || wrap_a !== 1'b1) begin errors++; $display("FAIL rsvd_wrap got q=%0d wrap=%b expected q=0 wrap=1", q_a, wrap_a); end
        clk1();
        checks++; if (q_a !== 4'd1 || wrap_a !== 1'b0) begin errors++; $display("FAIL rsvd_next got q=%0d wrap=%b expected q=1 wrap=0", q_a, wrap_a); end
    endtask

    initial begin
        res = 1'b0; en = 1'b0; up = 1'b1; load = 1'b0; d = 4'd0; mode = 2'b00;
        test_reset();
        test_default_count();
        test_down_load();
        test_saturate();
        test_oneshot();
        test_prescale();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
